// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with optional show-ahead read,
// registered almost-full/almost-empty flags and sticky error bits.
module sync_fifo_param #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 16,
    parameter int PTR       = 4,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wren,
    input  logic [WIDTH-1:0] datain,
    output logic             wrfull,
    output logic             almostfull,
    input  logic             rden,
    output logic [WIDTH-1:0] dataout,
    output logic             rdempty,
    output logic             almostempty,
    output logic [PTR:0]     usedw,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR:0] ONE     = (PTR+1)'(1);
    localparam logic [PTR:0] DEPTH_W = (PTR+1)'(DEPTH);
    localparam logic [PTR:0] AF_W    = (PTR+1)'(AFULL_TH);
    localparam logic [PTR:0] AE_W    = (PTR+1)'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR:0]     wr_ptr;
    logic [PTR:0]     rd_ptr;
    logic [PTR:0]     rd_ptr_nx;
    logic [PTR:0]     usedw_nx;
    logic             wr_acc;
    logic             rd_acc;
    logic             dout_en;
    logic [WIDTH-1:0] dout_nx;

    always_comb begin
        wr_acc    = wren & ~wrfull;
        rd_acc    = rden & ~rdempty;
        rd_ptr_nx = rd_ptr + ONE;
        usedw_nx  = usedw + (wr_acc ? ONE : '0) - (rd_acc ? ONE : '0);
    end

    // Show-ahead keeps the head entry registered; a lone entry being popped
    // alongside a write hands the head straight to the incoming word.
    always_comb begin
        dout_en = 1'b0;
        dout_nx = mem[rd_ptr[PTR-1:0]];
        if (FWFT == 0) begin
            dout_en = rd_acc;
        end else if (rd_acc) begin
            if (usedw > ONE) begin
                dout_en = 1'b1;
                dout_nx = mem[rd_ptr_nx[PTR-1:0]];
            end else if (wr_acc) begin
                dout_en = 1'b1;
                dout_nx = datain;
            end
        end else if (wr_acc && rdempty) begin
            dout_en = 1'b1;
            dout_nx = datain;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[PTR-1:0]] <= datain;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            usedw       <= '0;
            wrfull      <= 1'b0;
            rdempty     <= 1'b1;
            almostfull  <= 1'b0;
            almostempty <= 1'b1;
            dataout     <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr_nx;
            usedw       <= usedw_nx;
            wrfull      <= (usedw_nx == DEPTH_W);
            rdempty     <= (usedw_nx == '0);
            almostfull  <= (usedw_nx >= AF_W);
            almostempty <= (usedw_nx <= AE_W);
            if (dout_en) dataout <= dout_nx;
            if (wren & wrfull) overflow <= 1'b1;
            if (rden & rdempty) underflow <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (usedw == wr_ptr - rd_ptr)
                else $error("sync_fifo_param: usedw out of step with pointers");
            if (wren & wrfull)
                $display("sync_fifo_param: warning, write ignored while full");
            if (rden & rdempty)
                $display("sync_fifo_param: warning, read ignored while empty");
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: one normal-read and one show-ahead FIFO share stimulus
// and are compared against a queue model of the FIFO contents.
module tb_sync_fifo_param;

    localparam int W = 64;
    localparam int D = 16;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         wren;
    logic         rden;
    logic [W-1:0] datain;

    logic         wrfull_a, afull_a, rdempty_a, aempty_a, ovf_a, udf_a;
    logic [W-1:0] dataout_a;
    logic [P:0]   usedw_a;
    logic         wrfull_b, afull_b, rdempty_b, aempty_b, ovf_b, udf_b;
    logic [W-1:0] dataout_b;
    logic [P:0]   usedw_b;

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .PTR(P), .FWFT(0),
                      .AFULL_TH(12), .AEMPTY_TH(2)) dut_a (
        .clk(clk), .reset(reset), .wren(wren), .datain(datain),
        .wrfull(wrfull_a), .almostfull(afull_a), .rden(rden),
        .dataout(dataout_a), .rdempty(rdempty_a), .almostempty(aempty_a),
        .usedw(usedw_a), .overflow(ovf_a), .underflow(udf_a)
    );

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .PTR(P), .FWFT(1),
                      .AFULL_TH(12), .AEMPTY_TH(2)) dut_b (
        .clk(clk), .reset(reset), .wren(wren), .datain(datain),
        .wrfull(wrfull_b), .almostfull(afull_b), .rden(rden),
        .dataout(dataout_b), .rdempty(rdempty_b), .almostempty(aempty_b),
        .usedw(usedw_b), .overflow(ovf_b), .underflow(udf_b)
    );

    always #5 clk = ~clk;

    logic [W-1:0] model[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_a;
    logic [W-1:0] head_b;
    bit           ovf_m;
    bit           udf_m;
    bit           live = 1'b0;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [P:0] uw,
                             input logic fl, input logic af,
                             input logic em, input logic ae,
                             input logic ov, input logic un);
        int n;
        n = model.size();
        chk({tag, ".usedw"}, 64'(uw), 64'(n));
        chk({tag, ".wrfull"}, 64'(fl), 64'(n == D));
        chk({tag, ".almostfull"}, 64'(af), 64'(n >= 12));
        chk({tag, ".rdempty"}, 64'(em), 64'(n == 0));
        chk({tag, ".almostempty"}, 64'(ae), 64'(n <= 2));
        chk({tag, ".overflow"}, 64'(ov), 64'(ovf_m));
        chk({tag, ".underflow"}, 64'(un), 64'(udf_m));
    endtask

    // One clock of stimulus; the model advances on the same edge as the DUTs.
    task automatic step(input bit rs, input bit w, input bit r,
                        input logic [W-1:0] d);
        bit wa;
        bit ra;
        reset  = rs;
        wren   = w;
        rden   = r;
        datain = d;
        @(posedge clk);
        if (rs) begin
            model.delete();
            exp_q.delete();
            ovf_m  = 1'b0;
            udf_m  = 1'b0;
            last_a = '0;
            head_b = '0;
        end else begin
            wa = w && (model.size() < D);
            ra = r && (model.size() > 0);
            if (w && model.size() == D) ovf_m = 1'b1;
            if (r && model.size() == 0) udf_m = 1'b1;
            if (ra) exp_q.push_back(model.pop_front());
            if (wa) model.push_back(d);
            if (model.size() > 0) head_b = model[0];
        end
        live = 1'b1;
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                if (exp_q.size() > 0) last_a = exp_q.pop_front();
                chk("a.dataout", dataout_a, last_a);
                chk("b.dataout", dataout_b, head_b);
                chk_flags("a", usedw_a, wrfull_a, afull_a, rdempty_a,
                          aempty_a, ovf_a, udf_a);
                chk_flags("b", usedw_b, wrfull_b, afull_b, rdempty_b,
                          aempty_b, ovf_b, udf_b);
            end
        end
    end

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        step(1, 0, 0, '0);
        step(1, 1, 1, 64'h1234);
        for (int i = 1; i <= 16; i++) step(0, 1, 0, W'(i));
        step(0, 1, 0, 64'hAA);
        step(0, 1, 1, 64'hBB);
        step(0, 1, 0, 64'hCC);
        for (int i = 0; i < 17; i++) step(0, 0, 1, '0);
        step(0, 1, 1, 64'h77);
        step(0, 0, 0, '0);
        step(1, 0, 0, '0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, rnd64());
        for (int i = 0; i < 40; i++) step(0, 1, 1, rnd64());
        for (int i = 0; i < 8; i++) step(0, 0, 1, '0);
        for (int i = 0; i < 500; i++) begin
            bit w;
            bit r;
            bit rs;
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 50);
            rs = ($urandom_range(0, 149) == 0);
            if (model.size() == D && $urandom_range(0, 7) != 0) w = 1'b0;
            if (model.size() == 0 && $urandom_range(0, 7) != 0) r = 1'b0;
            step(rs, w, r, rnd64());
        end
        step(1, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, rnd64());
        step(1, 1, 1, rnd64());
        step(0, 0, 0, '0);
        step(0, 1, 0, 64'h55);
        step(0, 0, 0, '0);
        step(0, 1, 1, 64'h66);
        step(0, 0, 0, '0);
        step(0, 0, 1, '0);
        step(0, 0, 0, '0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
